// File: rtl/glip_upscale_pkg.sv
// Shared helpers for the GLIP width upscaler: parameter legality and fill-counter sizing.
package glip_upscale_pkg;

  function automatic bit factor_legal(input int factor);
    return (factor >= 2) && (factor <= 8);
  endfunction

  // Fill counter width, never narrower than one bit.
  function automatic int fill_width(input int factor);
    return (factor <= 2) ? 1 : $clog2(factor);
  endfunction

endpackage

// File: rtl/glip_upscale.sv
// Collects FACTOR narrow GLIP words into one little-endian wide word for user logic.
module glip_upscale
  import glip_upscale_pkg::*;
#(
  parameter int WIDTH_IN  = 16,
  parameter int FACTOR    = 2,
  parameter int WIDTH_OUT = WIDTH_IN * FACTOR
) (
  input  logic                            clk_logic,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [WIDTH_IN-1:0]             in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [WIDTH_OUT-1:0]            out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [fill_width(FACTOR)-1:0]   fill
);

  localparam int FW = fill_width(FACTOR);

  if (!factor_legal(FACTOR) || (WIDTH_OUT != WIDTH_IN * FACTOR)) begin : g_bad_param
    $error("glip_upscale: FACTOR must be 2..8 and WIDTH_OUT must equal WIDTH_IN*FACTOR");
  end

  logic [FW-1:0]                     cnt;
  logic [FACTOR-2:0][WIDTH_IN-1:0]   buf_q;
  logic                              last;
  logic                              out_free;
  logic                              accept;

  // Only the word that completes a group has to wait for the output register.
  assign last     = (cnt == FW'(FACTOR - 1));
  assign out_free = !out_valid || out_ready;
  assign in_ready = !flush && (!last || out_free);
  assign accept   = in_valid && in_ready;
  assign fill     = cnt;

  always_ff @(posedge clk_logic or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      buf_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept && !last) begin
        for (int k = 0; k < FACTOR - 1; k++) begin
          if (cnt == FW'(k)) buf_q[k] <= in_data;
        end
        cnt <= cnt + FW'(1);
      end
      // A completion replaces a draining word in the same cycle, so there is no bubble.
      if (accept && last) begin
        out_data  <= {in_data, buf_q};
        out_valid <= 1'b1;
        cnt       <= '0;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_glip_upscale.sv
// Self-checking bench for glip_upscale: directed FACTOR=2 cases plus a randomized FACTOR=4 run.
module tb_glip_upscale;

  logic        clk_logic;
  logic        rst;

  logic        a_flush;
  logic [15:0] a_in_data;
  logic        a_in_valid;
  logic        a_in_ready;
  logic [31:0] a_out_data;
  logic        a_out_valid;
  logic        a_out_ready;
  logic [0:0]  a_fill;

  logic        b_flush;
  logic [7:0]  b_in_data;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [31:0] b_out_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [1:0]  b_fill;

  int checks;
  int errors;

  glip_upscale #(.WIDTH_IN(16), .FACTOR(2)) dut_a (
    .clk_logic (clk_logic),
    .rst       (rst),
    .flush     (a_flush),
    .in_data   (a_in_data),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .out_data  (a_out_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .fill      (a_fill)
  );

  glip_upscale #(.WIDTH_IN(8), .FACTOR(4)) dut_b (
    .clk_logic (clk_logic),
    .rst       (rst),
    .flush     (b_flush),
    .in_data   (b_in_data),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .fill      (b_fill)
  );

  initial clk_logic = 1'b0;
  always #5 clk_logic = ~clk_logic;

  task automatic tick();
    @(posedge clk_logic);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive DUT A inputs, then let combinational in_ready settle.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic r, input logic f);
    a_in_valid  = v;
    a_in_data   = d;
    a_out_ready = r;
    a_flush     = f;
    #1;
  endtask

  logic [31:0] expq[$];
  logic [31:0] grp;
  int          gcnt;
  int          accepted;
  int          cyc;
  logic        exp_ready;
  logic        exp_valid;

  initial begin
    checks = 0;
    errors = 0;
    a_flush = 0; a_in_data = '0; a_in_valid = 0; a_out_ready = 1;
    b_flush = 0; b_in_data = '0; b_in_valid = 0; b_out_ready = 1;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", a_out_valid, 0);
    checkOutput("reset_out_data", a_out_data, 0);
    checkOutput("reset_fill", a_fill, 0);
    checkOutput("reset_in_ready", a_in_ready, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Basic pair
    applyStimulus(1, 16'h1111, 1, 0);
    checkOutput("basic_ready0", a_in_ready, 1);
    tick();
    checkOutput("basic_fill1", a_fill, 1);
    checkOutput("basic_nvalid", a_out_valid, 0);
    applyStimulus(1, 16'h2222, 1, 0);
    tick();
    checkOutput("basic_valid", a_out_valid, 1);
    checkOutput("basic_data", a_out_data, 32'h22221111);
    checkOutput("basic_fill0", a_fill, 0);
    applyStimulus(0, 16'h0, 1, 0);
    tick();
    checkOutput("basic_one_cycle", a_out_valid, 0);

    // Streaming eight words back to back
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, 16'(i), 1, 0);
      checkOutput("stream_ready", a_in_ready, 1);
      tick();
      checkOutput("stream_valid", a_out_valid, ((i % 2) == 0) ? 1 : 0);
      if ((i % 2) == 0)
        checkOutput("stream_data", a_out_data, {16'(i), 16'(i - 1)});
    end
    applyStimulus(0, 16'h0, 1, 0);
    tick();

    // Backpressure on the last word of a group
    applyStimulus(1, 16'h0001, 1, 0);
    tick();
    applyStimulus(1, 16'h0002, 1, 0);
    tick();
    checkOutput("bp_first", a_out_data, 32'h00020001);
    applyStimulus(1, 16'h0003, 0, 0);
    checkOutput("bp_third_ready", a_in_ready, 1);
    tick();
    checkOutput("bp_third_fill", a_fill, 1);
    checkOutput("bp_hold_valid", a_out_valid, 1);
    applyStimulus(1, 16'h0004, 0, 0);
    checkOutput("bp_fourth_stall", a_in_ready, 0);
    tick();
    checkOutput("bp_still_stall", a_in_ready, 0);
    checkOutput("bp_hold_data", a_out_data, 32'h00020001);
    checkOutput("bp_hold_fill", a_fill, 1);
    applyStimulus(1, 16'h0004, 1, 0);
    checkOutput("bp_release_ready", a_in_ready, 1);
    tick();
    checkOutput("bp_next_valid", a_out_valid, 1);
    checkOutput("bp_next_data", a_out_data, 32'h00040003);
    applyStimulus(0, 16'h0, 1, 0);
    tick();
    checkOutput("bp_drained", a_out_valid, 0);

    // Flush discards the partial word
    applyStimulus(1, 16'hAAAA, 1, 0);
    tick();
    checkOutput("flush_pre_fill", a_fill, 1);
    applyStimulus(1, 16'hBBBB, 1, 1);
    checkOutput("flush_blocks_ready", a_in_ready, 0);
    tick();
    checkOutput("flush_fill", a_fill, 0);
    checkOutput("flush_valid", a_out_valid, 0);
    applyStimulus(1, 16'h1234, 1, 0);
    tick();
    applyStimulus(1, 16'h5678, 1, 0);
    tick();
    checkOutput("flush_after_data", a_out_data, 32'h56781234);
    checkOutput("flush_after_valid", a_out_valid, 1);
    // Flush also drops an undrained wide word but keeps out_data
    applyStimulus(0, 16'h0, 0, 1);
    tick();
    checkOutput("flush_pending_dropped", a_out_valid, 0);
    checkOutput("flush_data_kept", a_out_data, 32'h56781234);

    // Asynchronous reset while a word is pending and one is partial
    applyStimulus(1, 16'h0001, 0, 0);
    tick();
    applyStimulus(1, 16'h0002, 0, 0);
    tick();
    applyStimulus(1, 16'h0003, 0, 0);
    tick();
    checkOutput("arst_pre_valid", a_out_valid, 1);
    checkOutput("arst_pre_fill", a_fill, 1);
    applyStimulus(0, 16'h0, 0, 0);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_valid", a_out_valid, 0);
    checkOutput("arst_fill", a_fill, 0);
    checkOutput("arst_data", a_out_data, 0);
    #2 rst = 1'b1;
    tick();
    applyStimulus(1, 16'h0005, 1, 0);
    tick();
    applyStimulus(1, 16'h0006, 1, 0);
    tick();
    checkOutput("arst_recover", a_out_data, 32'h00060005);
    checkOutput("arst_recover_valid", a_out_valid, 1);
    applyStimulus(0, 16'h0, 1, 0);
    tick();

    // FACTOR=4 directed bytes
    b_out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      b_in_valid = 1;
      b_in_data  = 8'(i * 8'h11);
      #1;
      tick();
    end
    checkOutput("f4_data", b_out_data, 32'h44332211);
    checkOutput("f4_valid", b_out_valid, 1);
    b_in_valid = 0;
    tick();
    checkOutput("f4_drained", b_out_valid, 0);

    // FACTOR=4 randomized traffic against a word-level model
    grp = '0;
    gcnt = 0;
    accepted = 0;
    cyc = 0;
    while (accepted < 1000 && cyc < 20000) begin
      b_in_valid  = ($urandom_range(3) != 0);
      b_in_data   = 8'($urandom);
      b_out_ready = ($urandom_range(4) < 3);
      #1;
      exp_valid = (expq.size() != 0);
      exp_ready = (gcnt < 3) || !exp_valid || b_out_ready;
      checkOutput("rand_in_ready", b_in_ready, exp_ready);
      checkOutput("rand_out_valid", b_out_valid, exp_valid);
      checkOutput("rand_fill", b_fill, gcnt[1:0]);
      if (exp_valid)
        checkOutput("rand_out_data", b_out_data, expq[0]);
      if (exp_valid && b_out_ready)
        void'(expq.pop_front());
      if (b_in_valid && exp_ready) begin
        grp = grp | (32'(b_in_data) << (8 * gcnt));
        gcnt++;
        accepted++;
        if (gcnt == 4) begin
          expq.push_back(grp);
          grp = '0;
          gcnt = 0;
        end
      end
      tick();
      cyc++;
    end
    checkOutput("rand_budget", (accepted >= 1000) ? 1 : 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
